// File: rtl/strmsplit.sv
// Length-prefixed packet demux: routes each whole packet to one of NS AXI-Stream
// outputs and derives TLAST from the header length. STRMSPLIT_DROPCNT_EN adds o_drops.

module strmsplit_lane #(
  parameter int DW = 32
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESETN,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          lin,
  input  logic          tready,
  output logic          tvalid,
  output logic [DW-1:0] tdata,
  output logic          tlast
);
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= din;
      tlast  <= lin;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end
endmodule

module strmsplit #(
  parameter int NS = 4,
  parameter int DW = 32
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [DW-1:0]    S_AXIS_TDATA,
  output logic [NS-1:0]    M_AXIS_TVALID,
  input  logic [NS-1:0]    M_AXIS_TREADY,
  output logic [DW*NS-1:0] M_AXIS_TDATA,
  output logic [NS-1:0]    M_AXIS_TLAST
`ifdef STRMSPLIT_DROPCNT_EN
  ,
  output logic [15:0]      o_drops
`endif
);
  localparam int B   = DW / 8;
  localparam int BW  = $clog2(B);
  localparam int CW  = 16 - BW;
  localparam int DSW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [16:0]    BM1   = 17'(B - 1);
  localparam logic [16-BW:0] ONE_W = 1;
  localparam logic [CW-1:0]  ONE_C = 1;

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   count, count_nx;
  logic [DSW-1:0]  sel, sel_nx, hdr_d;
  logic [16:0]     len_sum;
  logic [16-BW:0]  hdr_w, hdr_wm1;
  logic [CW-1:0]   hdr_cnt;
  logic            hdr_one, hdr_ok, tready, last_in;
  logic [NS-1:0]   port_rdy, load;

  // Word count ceil(L/B); L==0 still occupies the single header word
  assign len_sum = {1'b0, S_AXIS_TDATA[15:0]} + BM1;
  assign hdr_w   = len_sum[16:BW];
  assign hdr_one = (hdr_w <= ONE_W);
  assign hdr_wm1 = hdr_w - ONE_W;
  assign hdr_cnt = hdr_one ? '0 : hdr_wm1[CW-1:0];

  if (NS > 1) begin : g_dest
    assign hdr_d = S_AXIS_TDATA[16 +: DSW];
  end else begin : g_nodest
    assign hdr_d = '0;
  end
  assign hdr_ok   = (32'(hdr_d) < 32'(NS));
  assign port_rdy = ~M_AXIS_TVALID | M_AXIS_TREADY;
  assign S_AXIS_TREADY = tready;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
      count <= '0;
      sel   <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      sel   <= sel_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    sel_nx   = sel;
    tready   = 1'b0;
    load     = '0;
    last_in  = 1'b0;
    case (state)
      IDLE: begin
        if (hdr_ok) begin
          tready = port_rdy[hdr_d];
          if (S_AXIS_TVALID && tready) begin
            load[hdr_d] = 1'b1;
            last_in     = hdr_one;
            sel_nx      = hdr_d;
            count_nx    = hdr_cnt;
            if (!hdr_one) state_nx = ROUTE;
          end
        end else begin
          tready = 1'b1;
          if (S_AXIS_TVALID) begin
            count_nx = hdr_cnt;
            if (!hdr_one) state_nx = DROP;
          end
        end
      end
      ROUTE: begin
        tready = port_rdy[sel];
        if (S_AXIS_TVALID && tready) begin
          load[sel] = 1'b1;
          last_in   = (count == ONE_C);
          count_nx  = count - ONE_C;
          if (count == ONE_C) state_nx = IDLE;
        end
      end
      DROP: begin
        tready = 1'b1;
        if (S_AXIS_TVALID) begin
          count_nx = count - ONE_C;
          if (count == ONE_C) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  for (genvar k = 0; k < NS; k++) begin : g_lane
    strmsplit_lane #(.DW(DW)) u_lane (
      .S_AXI_ACLK    (S_AXI_ACLK),
      .S_AXI_ARESETN (S_AXI_ARESETN),
      .load          (load[k]),
      .din           (S_AXIS_TDATA),
      .lin           (last_in),
      .tready        (M_AXIS_TREADY[k]),
      .tvalid        (M_AXIS_TVALID[k]),
      .tdata         (M_AXIS_TDATA[k*DW +: DW]),
      .tlast         (M_AXIS_TLAST[k])
    );
  end

`ifdef STRMSPLIT_DROPCNT_EN
  logic drop_hit;
  assign drop_hit = (state == IDLE) && !hdr_ok && S_AXIS_TVALID;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                         o_drops <= '0;
    else if (drop_hit && (o_drops != 16'hffff)) o_drops <= o_drops + 16'd1;
  end
`endif

endmodule

// File: tb/tb_strmsplit.sv
// Scoreboard bench for strmsplit: NS=4 instance for routing/backpressure/reset,
// NS=3 instance for the invalid-destination drop path.

module tb_strmsplit;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [31:0]  s_tdata = '0;
  logic [3:0]   m_tvalid, m_tlast;
  logic [3:0]   m_tready = 4'hf;
  logic [127:0] m_tdata;

  logic         s3_tvalid = 1'b0;
  logic         s3_tready;
  logic [31:0]  s3_tdata = '0;
  logic [2:0]   m3_tvalid, m3_tlast;
  logic [2:0]   m3_tready = 3'b111;
  logic [95:0]  m3_tdata;
`ifdef STRMSPLIT_DROPCNT_EN
  logic [15:0]  drops4, drops3;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int stalls = 0;
  int unexp3 = 0;
  bit allow3 = 1'b0;
  logic [32:0] sb [4][$];
  logic [32:0] exp_w;

  always #5 clk = ~clk;

  strmsplit #(.NS(4), .DW(32)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast)
`ifdef STRMSPLIT_DROPCNT_EN
    , .o_drops     (drops4)
`endif
  );

  strmsplit #(.NS(3), .DW(32)) dut3 (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXIS_TVALID (s3_tvalid),
    .S_AXIS_TREADY (s3_tready),
    .S_AXIS_TDATA  (s3_tdata),
    .M_AXIS_TVALID (m3_tvalid),
    .M_AXIS_TREADY (m3_tready),
    .M_AXIS_TDATA  (m3_tdata),
    .M_AXIS_TLAST  (m3_tlast)
`ifdef STRMSPLIT_DROPCNT_EN
    , .o_drops     (drops3)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops the port's expected {tlast, tdata}
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (m_tvalid[k] && m_tready[k]) begin
          if (sb[k].size() == 0) chk($sformatf("unexpected_p%0d", k), 64'd1, 64'd0);
          else begin
            exp_w = sb[k].pop_front();
            chk($sformatf("out_p%0d", k), {31'd0, m_tlast[k], m_tdata[k*32 +: 32]}, {31'd0, exp_w});
          end
        end
      end
      if (!allow3 && (m3_tvalid != 3'b000)) unexp3++;
    end
  end

  task automatic send(input logic [31:0] w, input int port, input logic last);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = w;
    if (port >= 0) sb[port].push_back({last, w});
    @(negedge clk);
    while (!s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (!s_tready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (port >= 0) begin
      chk("lat_valid", {63'd0, m_tvalid[port]}, 64'd1);
      chk("lat_word", {31'd0, m_tlast[port], m_tdata[port*32 +: 32]}, {31'd0, last, w});
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic send3(input logic [31:0] w);
    s3_tvalid = 1'b1;
    s3_tdata  = w;
    @(negedge clk);
    chk("drop_tready", {63'd0, s3_tready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st0;
    #1;
    chk("rst_tvalid", {60'd0, m_tvalid}, 64'd0);
    chk("rst_tlast", {60'd0, m_tlast}, 64'd0);
    chk("rst_tdata", {63'd0, |m_tdata}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 12-byte packet to port 2
    send(32'h0002_000C, 2, 1'b0);
    send(32'hA1A1_0001, 2, 1'b0);
    send(32'hA1A1_0002, 2, 1'b1);
    idle();
    // single-word packets: L=3 and L=0, then L=5 -> 2 words
    send(32'h0001_0003, 1, 1'b1);
    idle();
    @(posedge clk);
    #1;
    send(32'h0000_0000, 0, 1'b1);
    send(32'h0003_0005, 3, 1'b0);
    send(32'hB0B0_0001, 3, 1'b1);
    // back-to-back packets, no bubble expected
    st0 = stalls;
    send(32'h0000_0008, 0, 1'b0);
    send(32'hC0C0_0000, 0, 1'b1);
    send(32'h0003_0008, 3, 1'b0);
    send(32'hC3C3_0000, 3, 1'b1);
    idle();
    chk("b2b_no_stall", 64'(stalls - st0), 64'd0);

    // port 2 backpressure mid-packet
    send(32'h0002_0010, 2, 1'b0);
    send(32'hD2D2_0001, 2, 1'b0);
    m_tready[2] = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'hD2D2_0002;
    repeat (5) begin
      @(negedge clk);
      chk("stall_tready", {63'd0, s_tready}, 64'd0);
      chk("stall_hold", {30'd0, m_tvalid[2], m_tlast[2], m_tdata[95:64]}, {30'd0, 1'b1, 1'b0, 32'hD2D2_0001});
    end
    @(posedge clk);
    #1 m_tready[2] = 1'b1;
    send(32'hD2D2_0002, 2, 1'b0);
    send(32'hD2D2_0003, 2, 1'b1);
    idle();

    // reset mid-packet
    send(32'h0002_0010, 2, 1'b0);
    send(32'hE2E2_0001, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {60'd0, m_tvalid}, 64'd0);
    chk("midrst_tlast", {60'd0, m_tlast}, 64'd0);
    chk("midrst_tdata", {63'd0, |m_tdata}, 64'd0);
    for (int k = 0; k < 4; k++) sb[k].delete();
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0001_0008, 1, 1'b0);
    send(32'hF1F1_0001, 1, 1'b1);
    idle();

    // NS=3: dest 3 is dropped silently, then a valid packet still routes
    send3(32'h0003_000C);
    send3(32'h5555_0001);
    send3(32'h5555_0002);
    allow3 = 1'b1;
    send3(32'h0002_0004);
    s3_tvalid = 1'b0;
    chk("ns3_route_valid", {61'd0, m3_tvalid}, 64'd4);
    chk("ns3_route_word", {31'd0, m3_tlast[2], m3_tdata[95:64]}, {31'd0, 1'b1, 32'h0002_0004});
    chk("drop_silent", 64'(unexp3), 64'd0);
`ifdef STRMSPLIT_DROPCNT_EN
    chk("drops_ns3", {48'd0, drops3}, 64'd1);
    chk("drops_ns4", {48'd0, drops4}, 64'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("sb_empty_p%0d", k), 64'(sb[k].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
